axi4_r_line_collector: RTL and testbench
========================================

# axi4_r_line_collector

Downstream consumer of the 2-entry AXI4 R-channel queue in the CoreRISCV AXI4 memory path. It drains R beats (resp, 64-bit data, last, 5-bit id, user) and assembles one read burst into a single cache-line-wide record. It merges the burst's worst-case response and flags protocol violations. It presents the line to the refill logic over a registered valid/ready handshake.

## Interface
Parameters:
- BEATS, 4, beats per line; legal 1..16
- DATA_W, 64, beat data width; must equal the queue's data width
- ID_W, 5, AXI ID width

Ports:
- clk  input  1  single clock; all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- io_in_ready  output  1  beat accepted when high with io_in_valid
- io_in_valid  input  1  beat present (queue io_deq_valid)
- io_in_bits_resp  input  2  AXI RRESP
- io_in_bits_data  input  DATA_W  beat data
- io_in_bits_last  input  1  RLAST
- io_in_bits_id  input  ID_W  RID
- io_in_bits_user  input  1  RUSER
- io_out_ready  input  1  line consumer ready
- io_out_valid  output  1  assembled line available
- io_out_bits_data  output  DATA_W*BEATS  beat i at [DATA_W*i +: DATA_W]
- io_out_bits_id  output  ID_W  ID of first beat
- io_out_bits_resp  output  2  numeric max of all beat resps (DECERR>SLVERR>EXOKAY>OKAY)
- io_out_bits_user  output  1  OR of all beat user bits
- io_out_bits_beats  output  5  beats actually received (1..BEATS)
- io_out_bits_proto_err  output  1  protocol violation detected in this line

## Operation
- States: IDLE (no beats held), COLLECT (1..BEATS-1 beats held), HOLD (line complete, io_out_valid=1).
- io_in_ready = 1 in IDLE/COLLECT, 0 in HOLD; 0 while reset asserted.
- Accept (valid&ready): write data into slot beat_cnt, resp accumulator = max(acc, resp), user acc |= user, beat_cnt += 1. First beat (IDLE) loads id and reinitialises accumulators (acc = beat's resp, user acc = beat's user), clears all unfilled slots to 0.
- Line completes when the accepted beat has last=1 or beat_cnt reaches BEATS; next state HOLD, beats output = count including that beat.
- Otherwise IDLE->COLLECT on first beat; COLLECT holds until completion.
- HOLD->IDLE when io_out_ready=1; outputs stable and unchanged while held.
- beat_cnt: 5-bit, reset 0, cleared on HOLD exit; never exceeds BEATS.
- BEATS=1: every beat completes a line; IDLE->HOLD directly.

## Timing
- Reset values: io_out_valid=0, all io_out_bits_*=0, state IDLE, beat_cnt=0.
- Latency: completing beat accepted in cycle N -> io_out_valid=1 in cycle N+1 (registered).
- Minimum spacing: BEATS accept cycles + 1 handshake cycle per line; no beat accepted in the cycle io_out_valid&io_out_ready fires (io_in_ready rises cycle after).
- io_out_valid never drops without io_out_ready; bits stable while valid.
- Reset mid-burst: partial line discarded, no io_out_valid produced; first beat after reset starts a new line.

## Configuration
- RLINE_PROTO_CHECK_EN defined: io_out_bits_proto_err=1 if last=1 arrives before beat BEATS (short burst), if beat BEATS arrives with last=0 (long burst; remaining beats form a new line, no resync), or if any later beat's id differs from the first beat's id.
- Undefined: no id comparison logic; io_out_bits_proto_err tied 0; termination rules unchanged.

## Test plan
- BEATS=4, beats D0..D3 = 0x1111.., 0x2222.., 0x3333.., 0x4444.., id=5, resp=0, last on 4th -> io_out_valid next cycle, data={D3,D2,D1,D0}, beats=4, resp=0, proto_err=0.
- Resps 0,2,1,3 across a 4-beat burst -> io_out_bits_resp=3; user bits 0,1,0,0 -> user=1.
- 2-beat burst with last on beat 2 -> beats=2, upper two slots 0, proto_err=1 with macro, 0 without.
- Hold io_out_ready=0 for 10 cycles with valid beats offered -> io_in_ready=0, outputs stable; assert ready -> line drains, io_in_ready=1 next cycle.
- Beat 3 id=6 in id=5 burst -> proto_err=1 (macro), id output=5; 4th beat with last=0 -> proto_err=1 and next beat starts new line.
- Assert reset after 2 beats -> io_out_valid stays 0; fresh 4-beat burst afterwards produces correct line with beats=4.

Source files
------------

// File: rtl/axi4_r_line_collector.sv
// axi4_r_line_collector: assembles one AXI4 R burst into a cache-line record with a registered valid/ready output.
// Optional protocol checking (short/long burst, RID mismatch) is enabled by defining RLINE_PROTO_CHECK_EN.
module axi4_r_line_collector #(
    parameter int BEATS  = 4,
    parameter int DATA_W = 64,
    parameter int ID_W   = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    io_in_ready,
    input  logic                    io_in_valid,
    input  logic [1:0]              io_in_bits_resp,
    input  logic [DATA_W-1:0]       io_in_bits_data,
    input  logic                    io_in_bits_last,
    input  logic [ID_W-1:0]         io_in_bits_id,
    input  logic                    io_in_bits_user,
    input  logic                    io_out_ready,
    output logic                    io_out_valid,
    output logic [DATA_W*BEATS-1:0] io_out_bits_data,
    output logic [ID_W-1:0]         io_out_bits_id,
    output logic [1:0]              io_out_bits_resp,
    output logic                    io_out_bits_user,
    output logic [4:0]              io_out_bits_beats,
    output logic                    io_out_bits_proto_err
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] HOLD    = 2'd2;

    logic [1:0]              state;
    logic [4:0]              beat_cnt, cnt_nxt;
    logic                    accept, first, full, done;
    logic [DATA_W*BEATS-1:0] line_nxt;
    logic [1:0]              resp_nxt;

    assign io_in_ready  = (state != HOLD) && !reset;
    assign io_out_valid = state == HOLD;
    assign accept       = io_in_valid && io_in_ready;
    assign first        = state == IDLE;
    assign cnt_nxt      = beat_cnt + 5'd1;
    assign full         = cnt_nxt == 5'(BEATS);
    assign done         = io_in_bits_last || full;
    assign resp_nxt     = (first || io_in_bits_resp > io_out_bits_resp) ? io_in_bits_resp : io_out_bits_resp;

    // Next line image: a new burst starts from an all-zero line so unfilled slots read 0
    always_comb begin
        line_nxt = first ? '0 : io_out_bits_data;
        line_nxt[DATA_W*beat_cnt +: DATA_W] = io_in_bits_data;
    end

    // Burst FSM plus accumulation straight into the output registers (invisible until HOLD)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            beat_cnt          <= '0;
            io_out_bits_data  <= '0;
            io_out_bits_id    <= '0;
            io_out_bits_resp  <= '0;
            io_out_bits_user  <= 1'b0;
            io_out_bits_beats <= '0;
        end else if (accept) begin
            state             <= done ? HOLD : COLLECT;
            beat_cnt          <= cnt_nxt;
            io_out_bits_data  <= line_nxt;
            io_out_bits_id    <= first ? io_in_bits_id : io_out_bits_id;
            io_out_bits_resp  <= resp_nxt;
            io_out_bits_user  <= io_in_bits_user | (!first && io_out_bits_user);
            io_out_bits_beats <= cnt_nxt;
        end else if (state == HOLD && io_out_ready) begin
            state    <= IDLE;
            beat_cnt <= '0;
        end
    end

`ifdef RLINE_PROTO_CHECK_EN
    logic err_nxt;

    // Short and long bursts both show up as RLAST disagreeing with the slot count
    always_comb err_nxt = (!first && (io_out_bits_proto_err || io_in_bits_id != io_out_bits_id)) || (io_in_bits_last != full);

    // Sticky per-line protocol error flag, restarted by the first beat
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            io_out_bits_proto_err <= 1'b0;
        else if (accept)
            io_out_bits_proto_err <= err_nxt;
    end
`else
    assign io_out_bits_proto_err = 1'b0;
`endif
endmodule

// File: tb/tb_axi4_r_line_collector.sv
// tb_axi4_r_line_collector: directed self-checking bench for axi4_r_line_collector (BEATS=4).
module tb_axi4_r_line_collector;
`ifdef RLINE_PROTO_CHECK_EN
    localparam logic PE = 1'b1;
`else
    localparam logic PE = 1'b0;
`endif
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         io_in_ready, io_in_valid = 1'b0;
    logic [1:0]   io_in_bits_resp = '0;
    logic [63:0]  io_in_bits_data = '0;
    logic         io_in_bits_last = 1'b0;
    logic [4:0]   io_in_bits_id = '0;
    logic         io_in_bits_user = 1'b0;
    logic         io_out_ready = 1'b0;
    logic         io_out_valid;
    logic [255:0] io_out_bits_data;
    logic [4:0]   io_out_bits_id;
    logic [1:0]   io_out_bits_resp;
    logic         io_out_bits_user;
    logic [4:0]   io_out_bits_beats;
    logic         io_out_bits_proto_err;
    int           tests = 0;
    int           fails = 0;

    localparam logic [63:0] D0 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] D1 = 64'h2222_2222_2222_2222;
    localparam logic [63:0] D2 = 64'h3333_3333_3333_3333;
    localparam logic [63:0] D3 = 64'h4444_4444_4444_4444;
    localparam logic [63:0] B0 = 64'hA0A0_0000_0000_00A0;
    localparam logic [63:0] B1 = 64'hA1A1_0000_0000_00A1;
    localparam logic [63:0] B2 = 64'hA2A2_0000_0000_00A2;
    localparam logic [63:0] B3 = 64'hA3A3_0000_0000_00A3;

    axi4_r_line_collector dut (
        .clk(clk), .reset(reset),
        .io_in_ready(io_in_ready), .io_in_valid(io_in_valid),
        .io_in_bits_resp(io_in_bits_resp), .io_in_bits_data(io_in_bits_data),
        .io_in_bits_last(io_in_bits_last), .io_in_bits_id(io_in_bits_id),
        .io_in_bits_user(io_in_bits_user), .io_out_ready(io_out_ready),
        .io_out_valid(io_out_valid), .io_out_bits_data(io_out_bits_data),
        .io_out_bits_id(io_out_bits_id), .io_out_bits_resp(io_out_bits_resp),
        .io_out_bits_user(io_out_bits_user), .io_out_bits_beats(io_out_bits_beats),
        .io_out_bits_proto_err(io_out_bits_proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [63:0] d, input logic [1:0] r, input logic l, input logic [4:0] id, input logic u);
        io_in_valid = 1'b1; io_in_bits_data = d; io_in_bits_resp = r;
        io_in_bits_last = l; io_in_bits_id = id; io_in_bits_user = u;
        chk("in_ready_beat", 256'(io_in_ready), 256'(1));
        @(posedge clk); #1;
        io_in_valid = 1'b0;
    endtask

    task automatic drain();
        io_out_ready = 1'b1;
        @(posedge clk); #1;
        io_out_ready = 1'b0;
        chk("drain_valid", 256'(io_out_valid), 256'(0));
        chk("drain_in_ready", 256'(io_in_ready), 256'(1));
    endtask

    task automatic chk_line(input string tag, input logic [255:0] d, input logic [4:0] id, input logic [1:0] r,
                            input logic u, input logic [4:0] n, input logic e);
        chk({tag, "_valid"}, 256'(io_out_valid), 256'(1));
        chk({tag, "_data"}, io_out_bits_data, d);
        chk({tag, "_id"}, 256'(io_out_bits_id), 256'(id));
        chk({tag, "_resp"}, 256'(io_out_bits_resp), 256'(r));
        chk({tag, "_user"}, 256'(io_out_bits_user), 256'(u));
        chk({tag, "_beats"}, 256'(io_out_bits_beats), 256'(n));
        chk({tag, "_err"}, 256'(io_out_bits_proto_err), 256'(e));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 256'(io_out_valid), 256'(0));
        chk("rst_in_ready", 256'(io_in_ready), 256'(0));
        chk("rst_data", io_out_bits_data, 256'(0));
        chk("rst_beats", 256'(io_out_bits_beats), 256'(0));
        chk("rst_resp_id", 256'({io_out_bits_resp, io_out_bits_id, io_out_bits_user, io_out_bits_proto_err}), 256'(0));
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 256'(io_in_ready), 256'(1));

        // Basic 4-beat line
        beat(D0, 2'd0, 1'b0, 5'd5, 1'b0);
        beat(D1, 2'd0, 1'b0, 5'd5, 1'b0);
        beat(D2, 2'd0, 1'b0, 5'd5, 1'b0);
        chk("mid_burst_valid", 256'(io_out_valid), 256'(0));
        beat(D3, 2'd0, 1'b1, 5'd5, 1'b0);
        chk_line("basic", {D3, D2, D1, D0}, 5'd5, 2'd0, 1'b0, 5'd4, 1'b0);
        drain();

        // Resp max / user OR, then a 10-cycle stall with beats offered
        beat(B0, 2'd0, 1'b0, 5'd1, 1'b0);
        beat(B1, 2'd2, 1'b0, 5'd1, 1'b1);
        beat(B2, 2'd1, 1'b0, 5'd1, 1'b0);
        beat(B3, 2'd3, 1'b1, 5'd1, 1'b0);
        chk_line("respmax", {B3, B2, B1, B0}, 5'd1, 2'd3, 1'b1, 5'd4, 1'b0);
        io_in_valid = 1'b1; io_in_bits_data = D0; io_in_bits_last = 1'b1; io_in_bits_id = 5'd9;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("stall_in_ready", 256'(io_in_ready), 256'(0));
            chk("stall_valid", 256'(io_out_valid), 256'(1));
            chk("stall_data", io_out_bits_data, {B3, B2, B1, B0});
            chk("stall_id_beats", 256'({io_out_bits_id, io_out_bits_beats}), 256'({5'd1, 5'd4}));
        end
        drain();
        io_in_valid = 1'b0;
        chk("no_accept_on_drain", 256'(io_out_valid), 256'(0));

        // Short burst: stale upper slots must be cleared
        beat(D2, 2'd1, 1'b0, 5'd3, 1'b0);
        beat(D3, 2'd0, 1'b1, 5'd3, 1'b0);
        chk_line("short", {128'd0, D3, D2}, 5'd3, 2'd1, 1'b0, 5'd2, PE);
        drain();

        // RID mismatch on beat 3
        beat(D0, 2'd0, 1'b0, 5'd5, 1'b0);
        beat(D1, 2'd0, 1'b0, 5'd5, 1'b0);
        beat(D2, 2'd0, 1'b0, 5'd6, 1'b0);
        beat(D3, 2'd0, 1'b1, 5'd5, 1'b0);
        chk_line("idmis", {D3, D2, D1, D0}, 5'd5, 2'd0, 1'b0, 5'd4, PE);
        drain();

        // Long burst: 4th beat without last closes the line, next beat starts a new one
        beat(B0, 2'd0, 1'b0, 5'd7, 1'b0);
        beat(B1, 2'd0, 1'b0, 5'd7, 1'b0);
        beat(B2, 2'd0, 1'b0, 5'd7, 1'b0);
        beat(B3, 2'd0, 1'b0, 5'd7, 1'b0);
        chk_line("long", {B3, B2, B1, B0}, 5'd7, 2'd0, 1'b0, 5'd4, PE);
        drain();
        beat(D1, 2'd2, 1'b1, 5'd7, 1'b1);
        chk_line("long_tail", {192'd0, D1}, 5'd7, 2'd2, 1'b1, 5'd1, PE);
        drain();

        // Reset mid-burst discards the partial line
        beat(D0, 2'd3, 1'b0, 5'd2, 1'b1);
        beat(D1, 2'd3, 1'b0, 5'd2, 1'b1);
        reset = 1'b1;
        #1;
        chk("midrst_valid", 256'(io_out_valid), 256'(0));
        chk("midrst_data", io_out_bits_data, 256'(0));
        chk("midrst_beats", 256'(io_out_bits_beats), 256'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("after_rst_valid", 256'(io_out_valid), 256'(0));
        beat(B0, 2'd0, 1'b0, 5'd4, 1'b0);
        beat(B1, 2'd1, 1'b0, 5'd4, 1'b0);
        beat(B2, 2'd0, 1'b0, 5'd4, 1'b0);
        beat(B3, 2'd0, 1'b1, 5'd4, 1'b0);
        chk_line("fresh", {B3, B2, B1, B0}, 5'd4, 2'd1, 1'b0, 5'd4, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
